// File: rtl/edsac_store_access.sv
// Bit-serial access controller for the 32 mercury-delay tanks of the main store.
// Optional long-word (36-slot) transfers are enabled by defining LONG_WORD_EN.
module edsac_store_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [9:0]  req_addr,
    input  logic        req_long,
    input  logic [35:0] wr_data,
    output logic        rsp_valid,
    output logic [35:0] rd_data,
    output logic [9:0]  pos,
    output logic [3:0]  mib,
    output logic [31:0] tn_in,
    output logic [31:0] tn_clr,
    output logic [31:0] tn_out,
    input  logic [31:0] mob
);
    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | request latched, waiting for the word to circulate round
    // XFER  | strobing the addressed tank, one bit slot per cycle
    // DONE  | one-cycle response pulse
    localparam int TANKS          = 32;
    localparam int WORD_BITS      = 18;
    localparam int WORDS_PER_TANK = 32;
    localparam int CIRC           = WORD_BITS * WORDS_PER_TANK;
    localparam logic [9:0] POS_MAX = 10'(CIRC - 1);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    state_t      state, state_nx;
    logic        accept;
    logic [4:0]  word_sel;
    logic [9:0]  base_sel;
    logic [9:0]  start_sel;
    logic [35:0] data_sel;
    logic        long_sel;

    logic        write_q;
    logic        long_q;
    logic [4:0]  tank_q;
    logic [9:0]  start_q;
    logic [35:0] data_q;
    logic [5:0]  slot;
    logic [5:0]  last_slot;
    logic [TANKS-1:0] tank_oh;

    assign accept = req_valid & req_ready;

`ifdef LONG_WORD_EN
    assign long_sel = req_long;
    assign word_sel = req_long ? {req_addr[4:1], 1'b0} : req_addr[4:0];
    assign data_sel = req_long ? wr_data : {19'd0, wr_data[16:0]};
`else
    logic unused_inputs;
    assign unused_inputs = ^{req_long, wr_data[35:17]};
    assign long_sel = 1'b0;
    assign word_sel = req_addr[4:0];
    assign data_sel = {19'd0, wr_data[16:0]};
`endif

    // base = word*18; the pad slot of a short word falls out as data_q[17] = 0
    assign base_sel  = {1'b0, word_sel, 4'b0000} + {4'b0000, word_sel, 1'b0};
    assign start_sel = (base_sel == 10'd0) ? POS_MAX : base_sel - 10'd1;
    assign last_slot = long_q ? 6'd35 : 6'd17;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= 10'd0;
        end else if (pos == POS_MAX) begin
            pos <= 10'd0;
        end else begin
            pos <= pos + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Leaving WAIT one slot early puts XFER slot 0 on the cycle where pos == base.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (pos == start_sel) ? XFER : WAIT;
            WAIT: if (pos == start_q) state_nx = XFER;
            XFER: if (slot == last_slot) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            long_q  <= 1'b0;
            tank_q  <= 5'd0;
            start_q <= 10'd0;
            data_q  <= 36'd0;
            slot    <= 6'd0;
            rd_data <= 36'd0;
        end else begin
            if (accept) begin
                write_q <= req_write;
                long_q  <= long_sel;
                tank_q  <= req_addr[9:5];
                start_q <= start_sel;
                data_q  <= data_sel;
                rd_data <= 36'd0;
            end
            if (state == XFER) begin
                slot <= slot + 6'd1;
                if (!write_q) rd_data[slot] <= mob[tank_q];
            end else begin
                slot <= 6'd0;
            end
        end
    end

    assign tank_oh = TANKS'(1) << tank_q;

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == DONE);
        tn_in     = '0;
        tn_clr    = '0;
        tn_out    = '0;
        mib       = '0;
        if (state == XFER) begin
            if (write_q) begin
                tn_in              = tank_oh;
                tn_clr             = tank_oh;
                mib[tank_q[4:3]]   = data_q[slot];
            end else begin
                tn_out = tank_oh;
            end
        end
    end

endmodule

// File: tb/tb_edsac_store_access.sv
// Directed bench for edsac_store_access with a bit-level model of the 32 tanks.
module tb_edsac_store_access;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [9:0]  req_addr = 10'd0;
    logic        req_long = 1'b0;
    logic [35:0] wr_data = 36'd0;
    logic        rsp_valid;
    logic [35:0] rd_data;
    logic [9:0]  pos;
    logic [3:0]  mib;
    logic [31:0] tn_in, tn_clr, tn_out;
    logic [31:0] mob;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0]  tb_pos;
    bit          tank_mem [32][576];
    bit          pre_go = 1'b0;
    logic [35:0] pre_pat = 36'd0;

    int          lat, in_first, in_last, in_cnt, out_first, out_last, out_cnt, stray;
    logic [35:0] bits;

    edsac_store_access dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_long(req_long),
        .wr_data(wr_data), .rsp_valid(rsp_valid), .rd_data(rd_data), .pos(pos),
        .mib(mib), .tn_in(tn_in), .tn_clr(tn_clr), .tn_out(tn_out), .mob(mob)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_pos <= 10'd0;
        else        tb_pos <= (tb_pos == 10'd575) ? 10'd0 : tb_pos + 10'd1;
    end

    // Tank model: store mib on enabled slots, present the circulating bit on mob.
    always @(negedge clk) begin
        if (pre_go) begin
            for (int i = 0; i < 36; i++) tank_mem[0][324 + i] = pre_pat[i];
        end
        for (int t = 0; t < 32; t++) begin
            if (tn_in[t] === 1'b1) tank_mem[t][tb_pos] = mib[t / 8];
            mob[t] = tank_mem[t][tb_pos];
        end
    end

    task automatic accept(input logic wr, input logic [9:0] addr, input logic lng,
                          input logic [35:0] data, input int p);
        int guard;
        guard = 0;
        @(negedge clk);
        while (tb_pos != 10'(p) && guard < 1200) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 1200 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_ready: pos %0d ready %b, required pos %0d ready 1", tb_pos, req_ready, p);
        end
        req_write = wr;
        req_addr  = addr;
        req_long  = lng;
        wr_data   = data;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Records what the DUT does until rsp_valid (lat = -1 on timeout).
    task automatic watch(input int tank, input int limit);
        int rack;
        rack = tank / 8;
        lat = -1; in_first = -1; in_last = -1; in_cnt = 0;
        out_first = -1; out_last = -1; out_cnt = 0; bits = '0; stray = 0;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (pos !== tb_pos) stray++;
            if (tn_clr !== tn_in) stray++;
            if ((tn_in & ~(32'd1 << tank)) != 0 || (tn_out & ~(32'd1 << tank)) != 0) stray++;
            if (tn_in[tank] && tn_out[tank]) stray++;
            if (!tn_in[tank] && mib != 4'd0) stray++;
            if ((mib & ~(4'd1 << rack)) != 4'd0) stray++;
            if (tn_in[tank]) begin
                if (in_first < 0) in_first = int'(tb_pos);
                in_last = int'(tb_pos);
                if (in_cnt < 36) bits[in_cnt] = mib[rack];
                in_cnt++;
            end
            if (tn_out[tank]) begin
                if (out_first < 0) out_first = int'(tb_pos);
                out_last = int'(tb_pos);
                out_cnt++;
            end
            if (rsp_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rsp_valid, mib, tn_in, tn_clr, tn_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_strobes: rsp %b mib %h in %h clr %h out %h, required all 0", rsp_valid, mib, tn_in, tn_clr, tn_out);
        end
        n_cmp++;
        if (pos !== 10'd0 || rd_data !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_pos_data: pos %0d rd_data %h, required 0 and 0", pos, rd_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || pos !== 10'd1) begin
            n_bad++;
            $display("FAIL reset_release: ready %b pos %0d, required 1 and 1", req_ready, pos);
        end
    endtask

    task automatic test_write();
        accept(1'b1, 10'h045, 1'b0, 36'h1ABCD, 0);
        watch(2, 700);
        n_cmp++;
        if (lat !== 108) begin n_bad++; $display("FAIL write_latency: got %0d required 108", lat); end
        n_cmp++;
        if (in_first !== 90 || in_last !== 107 || in_cnt !== 18) begin
            n_bad++;
            $display("FAIL write_window: %0d..%0d (%0d slots), required 90..107 (18)", in_first, in_last, in_cnt);
        end
        n_cmp++;
        if (bits[17:0] !== 18'h1ABCD) begin
            n_bad++;
            $display("FAIL write_mib_bits: got %h required 1abcd", bits[17:0]);
        end
        n_cmp++;
        if (stray !== 0 || out_cnt !== 0) begin
            n_bad++;
            $display("FAIL write_stray: stray %0d out_cnt %0d, required 0 and 0", stray, out_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL write_rsp_pulse: rsp %b ready %b, required 0 and 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_read();
        accept(1'b0, 10'h045, 1'b0, 36'd0, 200);
        watch(2, 700);
        n_cmp++;
        if (lat !== 484) begin n_bad++; $display("FAIL read_latency: got %0d required 484", lat); end
        n_cmp++;
        if (out_first !== 90 || out_last !== 107 || out_cnt !== 18 || in_cnt !== 0) begin
            n_bad++;
            $display("FAIL read_window: %0d..%0d (%0d) in_cnt %0d, required 90..107 (18) and 0", out_first, out_last, out_cnt, in_cnt);
        end
        n_cmp++;
        if (rd_data[16:0] !== 17'h1ABCD || rd_data[35:18] !== 18'd0) begin
            n_bad++;
            $display("FAIL read_data: got %h required 1abcd with [35:18]=0", rd_data);
        end
        n_cmp++;
        if (stray !== 0) begin n_bad++; $display("FAIL read_stray: got %0d required 0", stray); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rd_data[16:0] !== 17'h1ABCD) begin
            n_bad++;
            $display("FAIL read_hold: got %h required 1abcd", rd_data[16:0]);
        end
    endtask

    task automatic test_accept_edges();
        accept(1'b0, 10'h045, 1'b0, 36'd0, 89);
        watch(2, 700);
        n_cmp++;
        if (lat !== 19 || out_first !== 90) begin
            n_bad++;
            $display("FAIL edge_base_m1: latency %0d first %0d, required 19 and 90", lat, out_first);
        end
        accept(1'b0, 10'h045, 1'b0, 36'd0, 90);
        watch(2, 700);
        n_cmp++;
        if (lat !== 594 || out_first !== 90 || out_cnt !== 18) begin
            n_bad++;
            $display("FAIL edge_base: latency %0d first %0d slots %0d, required 594 90 18", lat, out_first, out_cnt);
        end
        n_cmp++;
        if (rd_data[16:0] !== 17'h1ABCD) begin
            n_bad++;
            $display("FAIL edge_base_data: got %h required 1abcd", rd_data[16:0]);
        end
    endtask

    task automatic test_top_word();
        accept(1'b1, 10'h3FF, 1'b0, 36'h15A5A, 10);
        watch(31, 700);
        n_cmp++;
        if (lat !== 566) begin n_bad++; $display("FAIL top_latency: got %0d required 566", lat); end
        n_cmp++;
        if (in_first !== 558 || in_last !== 575 || in_cnt !== 18) begin
            n_bad++;
            $display("FAIL top_window: %0d..%0d (%0d), required 558..575 (18)", in_first, in_last, in_cnt);
        end
        n_cmp++;
        if (bits[17:0] !== 18'h15A5A || stray !== 0) begin
            n_bad++;
            $display("FAIL top_mib3: bits %h stray %0d, required 15a5a and 0", bits[17:0], stray);
        end
        n_cmp++;
        if (pos !== 10'd0 || tn_in !== 32'd0 || tn_clr !== 32'd0) begin
            n_bad++;
            $display("FAIL top_wrap: pos %0d in %h clr %h, required 0 0 0", pos, tn_in, tn_clr);
        end
        accept(1'b0, 10'h3FF, 1'b0, 36'd0, 300);
        watch(31, 700);
        n_cmp++;
        if (lat !== 276 || rd_data[16:0] !== 17'h15A5A) begin
            n_bad++;
            $display("FAIL top_readback: latency %0d data %h, required 276 and 15a5a", lat, rd_data[16:0]);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int rsp_seen;
        accept(1'b1, 10'h120, 1'b0, 36'h1FFFF, 100);
        guard = 0;
        @(negedge clk);
        while (tb_pos != 10'd5 && guard < 700) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (tn_in[9] !== 1'b1 || guard >= 700) begin
            n_bad++;
            $display("FAIL rst_mid_active: tn_in %h, required bit 9 high at pos 5", tn_in);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tn_in, tn_clr, tn_out, mib} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_strobes: in %h clr %h out %h mib %h, required all 0", tn_in, tn_clr, tn_out, mib);
        end
        n_cmp++;
        if (pos !== 10'd0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_pos: pos %0d rsp %b, required 0 and 0", pos, rsp_valid);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rsp_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) rsp_seen++;
        end
        n_cmp++;
        if (rsp_seen !== 0) begin
            n_bad++;
            $display("FAIL rst_mid_no_rsp: %0d bad cycles, required 0", rsp_seen);
        end
        accept(1'b0, 10'h045, 1'b0, 36'd0, 50);
        watch(2, 700);
        n_cmp++;
        if (lat !== 58 || rd_data[16:0] !== 17'h1ABCD) begin
            n_bad++;
            $display("FAIL rst_mid_recover: latency %0d data %h, required 58 and 1abcd", lat, rd_data[16:0]);
        end
    endtask

`ifdef LONG_WORD_EN
    task automatic test_long();
        pre_pat = 36'h96C3A5E1F;
        @(posedge clk);
        pre_go = 1'b1;
        @(posedge clk);
        pre_go = 1'b0;
        accept(1'b0, 10'h013, 1'b1, 36'd0, 300);
        watch(0, 700);
        n_cmp++;
        if (lat !== 60) begin n_bad++; $display("FAIL long_latency: got %0d required 60", lat); end
        n_cmp++;
        if (out_first !== 324 || out_last !== 359 || out_cnt !== 36) begin
            n_bad++;
            $display("FAIL long_window: %0d..%0d (%0d), required 324..359 (36)", out_first, out_last, out_cnt);
        end
        n_cmp++;
        if (rd_data !== 36'h96C3A5E1F) begin
            n_bad++;
            $display("FAIL long_data: got %h required 96c3a5e1f", rd_data);
        end
    endtask
`else
    task automatic test_long_ignored();
        accept(1'b0, 10'h045, 1'b1, 36'd0, 300);
        watch(2, 700);
        n_cmp++;
        if (lat !== 384 || out_first !== 90 || out_cnt !== 18) begin
            n_bad++;
            $display("FAIL long_ignored: latency %0d first %0d slots %0d, required 384 90 18", lat, out_first, out_cnt);
        end
        n_cmp++;
        if (rd_data !== 36'h1ABCD) begin
            n_bad++;
            $display("FAIL long_ignored_data: got %h required 00001abcd", rd_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_accept_edges();
        test_top_word();
        test_reset_mid();
`ifdef LONG_WORD_EN
        test_long();
`else
        test_long_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
